instr_fetch_ctrl: RTL
=====================

# instr_fetch_ctrl

Sequencer for the 32-word instruction memory in the single-cycle datapath. It owns the program counter, loads the program image into instruction memory through a valid/ready stream after reset, then runs fetch. During fetch it presents the current PC as the memory read address, applies stall/branch/jump redirects, and stops on an address fault or halt condition.

## Interface
- `DEPTH`, 32: instruction memory depth in 32-bit words; must be a power of 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after load; word-aligned, less than DEPTH*4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `load_valid`  in  1: a program word is offered.
- `load_ready`  out  1: the block accepts load words.
- `load_data`  in  32: program word.
- `load_last`  in  1: marks the final program word.
- `mem_we`  out  1: instruction memory write enable.
- `mem_waddr`  out  32: byte write address, always word-aligned.
- `mem_wdata`  out  32: write data.
- `mem_raddr`  out  32: byte read address to instruction memory.
- `mem_rdata`  in  32: instruction from instruction memory (combinational read).
- `stall`  in  1: hold the PC this cycle.
- `branch_taken`  in  1: redirect to `branch_target`.
- `branch_target`  in  32: branch destination.
- `jump`  in  1: redirect to `jump_target`.
- `jump_target`  in  32: jump destination.
- `instr_out`  out  32: instruction at the PC.
- `instr_valid`  out  1: `instr_out` is executable this cycle.
- `pc_out`  out  32: current PC.
- `pc_plus4`  out  32: PC + 4.
- `halted`  out  1: HALT state.
- `fault`  out  1: sticky flag, set on a bad redirect or a PC overrun.

## Operation
- States: LOAD (entered from reset), RUN, HALT.
- LOAD:
  - `load_ready`=1.
  - A word is accepted when `load_valid && load_ready`. An accepted word drives `mem_we`=1, `mem_waddr`=wcnt*4 and `mem_wdata`=`load_data` in the same cycle.
  - wcnt increments by 1 on each accepted word.
  - Go to RUN when an accepted word has `load_last`=1, or when the accepted word fills address DEPTH-1 (wcnt wraps to 0).
  - On entry to RUN, pc ← RESET_PC.
- RUN:
  - `load_ready`=0 and `mem_we`=0.
  - `mem_raddr`=pc and `instr_out`=`mem_rdata`.
  - `instr_valid`=!`stall`.
  - Next-PC priority, highest first: stall (hold), jump, branch_taken, pc+4.
  - Redirects are ignored while `stall`=1.
  - Redirect fault: if the chosen target has bits [1:0]≠0, or is at least DEPTH*4, then set `fault`, go to HALT, and leave pc unchanged.
  - Overrun fault: if pc+4 reaches DEPTH*4 without a redirect, set `fault` and go to HALT.
- HALT:
  - `halted`=1 and `instr_valid`=0.
  - pc is frozen and `load_ready`=0.
  - Only `rst_n` exits HALT.
- Arithmetic: 32-bit, and `pc_plus4` wraps modulo 2^32. Fault checks use the unwrapped comparison against DEPTH*4.

## Timing
- Reset values:
  - State LOAD, wcnt=0, pc=RESET_PC.
  - `load_ready`=1, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0.
  - `instr_valid`=0, `halted`=0, `fault`=0.
  - `mem_raddr`=`pc_out`=RESET_PC and `pc_plus4`=RESET_PC+4.
- `mem_we`, `mem_waddr` and `mem_wdata` are combinational from the handshake, so the write occurs with zero added latency.
- First `instr_valid`=1 is the cycle after the edge that accepted the last word.
- PC update: the redirect decided in cycle N is visible on `pc_out` in cycle N+1. Fetch has zero latency, since the memory read is combinational.
- `halted` and `fault` assert the cycle after the faulting edge.
- `load_valid` with `load_ready`=0 is ignored and never writes memory.
- Reset mid-load or mid-run takes effect immediately and asynchronously. All state returns to reset values, and previously written memory contents are left intact but are reloaded.

## Configuration
- `IFETCH_HALT_ON_SYSCALL_EN` defined:
  - In RUN, an unstalled `instr_out`==32'h0000_000C (syscall) is presented with `instr_valid`=1 for that one cycle.
  - The block then enters HALT with `fault`=0.
- Not defined: syscall is an ordinary instruction and the PC advances normally.

## Test plan
- Load 4 words (0x20080005, 0x20090003, 0x01095020, 0x0000000C), with `load_last` on the 4th:
  - memory writes go to addresses 0, 4, 8 and 12;
  - `instr_valid` rises the next cycle with `pc_out`=0 and `instr_out`=0x20080005.
- Load stream with `load_valid` toggling every other cycle, and DEPTH=32 words with no `load_last`:
  - exactly 32 writes occur;
  - the block auto-enters RUN after address 124.
- RUN with `jump`=1/0x10 and `branch_taken`=1/0x20 in the same cycle → next `pc_out`=0x10. Adding `stall`=1 in that cycle → `pc_out` holds and `instr_valid`=0.
- `branch_target`=0x6 → `fault`=1 and `halted`=1 next cycle, `pc_out` unchanged. A later `load_valid` produces no `mem_we`.
- Sequential run from pc 0x7C with no redirect → `fault`=1 and `halted`=1, `pc_out` stays 0x7C.
- Syscall at 0x0C:
  - with `IFETCH_HALT_ON_SYSCALL_EN` → `halted`=1, `fault`=0, `pc_out`=0x0C;
  - without it → `pc_out`=0x10.
  - Assert `rst_n`=0 mid-run → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction memory loader and fetch sequencer: streams the program image in, then owns the PC.
// Optional feature: define IFETCH_HALT_ON_SYSCALL_EN to halt cleanly on a syscall word (32'h0000_000C).
module instr_fetch_ctrl #(
    parameter int unsigned DEPTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH * 4);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wcnt_q, wcnt_d;
    logic [31:0]     pc_q, pc_d;
    logic            fault_q, fault_d;

    logic [31:0]     target;
    logic            redirect;
    logic            bad_target;
    logic [32:0]     seq_next;
    logic            syscall_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            wcnt_q  <= '0;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Redirect checks use a 33-bit compare so a huge target cannot alias back into range.
    assign target     = jump ? jump_target : branch_target;
    assign redirect   = jump | branch_taken;
    assign bad_target = (target[1:0] != 2'b00) || ({1'b0, target} >= LIMIT);
    assign seq_next   = {1'b0, pc_q} + 33'd4;

`ifdef IFETCH_HALT_ON_SYSCALL_EN
    assign syscall_hit = (mem_rdata == 32'h0000_000C);
`else
    assign syscall_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        pc_d        = pc_q;
        fault_d     = fault_q;
        load_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        instr_valid = 1'b0;

        case (state_q)
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = {{(30 - AW){1'b0}}, wcnt_q, 2'b00};
                    mem_wdata = load_data;
                    wcnt_d    = wcnt_q + 1'b1;
                    if (load_last || (wcnt_q == AW'(DEPTH - 1))) begin
                        state_d = ST_RUN;
                        wcnt_d  = '0;
                        pc_d    = RESET_PC;
                    end
                end
            end
            ST_RUN: begin
                instr_valid = !stall;
                if (!stall) begin
                    if (syscall_hit) begin
                        state_d = ST_HALT;
                    end else if (redirect) begin
                        if (bad_target) begin
                            fault_d = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            pc_d = target;
                        end
                    end else if (seq_next >= LIMIT) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = seq_next[31:0];
                    end
                end
            end
            ST_HALT: begin
            end
            default: state_d = ST_HALT;
        endcase
    end

    assign mem_raddr = pc_q;
    assign pc_out    = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign instr_out = mem_rdata;
    assign halted    = (state_q == ST_HALT);
    assign fault     = fault_q;

endmodule
